stack_unit: RTL and testbench

- Hardware LIFO stack directly downstream of the control unit.
- Consumes the control unit's stk_push/stk_pop strobes and returns stk_pop_valid plus pop data.
- Pop data is written to the register file when the control unit selects the stack write source (stwr=3).
- Holds return/saved values independently of data memory; reports full/empty and sticky overflow/underflow errors.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/stack_ram.sv | 25 ++
 rtl/stack_unit.sv | 141 ++++++++++++++
 tb/tb_stack_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stack FSM states, stack word width and the
// register-file write-source code that selects stack pop data.
package cpu_pkg;
  localparam int         STK_DATA_W = 16;
  // stwr encoding used by the control unit to route pop_data into the RF
  localparam logic [1:0] STWR_STACK = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    POP_RD   = 2'd1,
    POP_HOLD = 2'd2
  } stk_state_t;
endpackage

// File: rtl/stack_ram.sv
// Stack storage array: DEPTH x DATA_W, synchronous write, combinational read.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (async read port).
// The array has no reset; the read result is registered by the caller.
module stack_ram
  import cpu_pkg::*;
#(
  parameter int DATA_W = STK_DATA_W,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/stack_unit.sv
// Hardware LIFO stack driven by control-unit push/pop level strobes.
// Ports:
//   clk, init_n        clock, async active-low reset
//   stk_push, stk_pop  level requests; only rising edges start an operation
//   push_data          value written on a push
//   stk_clr            sync clear of the sticky error flags
//   pop_data           registered popped value, qualified by stk_pop_valid
//   stk_pop_valid      high from pop completion until stk_pop falls
//   stk_full/empty     combinational from sp
//   stk_ovf/udf        sticky error flags
//   sp                 current entry count (debug)
module stack_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = STK_DATA_W,
  parameter int DEPTH  = 16,
  parameter int SP_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              stk_push,
  input  logic              stk_pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic              stk_clr,
  output logic [DATA_W-1:0] pop_data,
  output logic              stk_pop_valid,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_ovf,
  output logic              stk_udf,
  output logic [SP_W-1:0]   sp
);
  localparam int AW = $clog2(DEPTH);

  stk_state_t        state_q, state_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              push_q, pop_q;
  logic              push_re, pop_re;
  logic              ovf_set, udf_set;
  logic              we;
  logic [AW-1:0]     raddr;
  logic [DATA_W-1:0] rdata;

  assign push_re   = stk_push & ~push_q;
  assign pop_re    = stk_pop & ~pop_q;
  assign stk_full  = (sp_q == SP_W'(DEPTH));
  assign stk_empty = (sp_q == '0);
  // Top-of-stack address; only consulted in POP_RD where sp_q >= 1
  assign raddr     = sp_q[AW-1:0] - AW'(1);

  stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (sp_q[AW-1:0]),
    .wdata (push_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    pop_data_d = pop_data_q;
    valid_d    = valid_q;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (push_re && pop_re) begin
          // Simultaneous requests are ambiguous: do nothing, flag both
          ovf_set = 1'b1;
          udf_set = 1'b1;
        end else if (push_re) begin
          if (stk_full) ovf_set = 1'b1;
          else begin
            we   = 1'b1;
            sp_d = sp_q + SP_W'(1);
          end
        end else if (pop_re) begin
          if (stk_empty) begin
            // Ride out the pop window without ever asserting valid
            udf_set = 1'b1;
            state_d = POP_HOLD;
          end else begin
            state_d = POP_RD;
          end
        end
      end
      POP_RD: begin
        pop_data_d = rdata;
        sp_d       = sp_q - SP_W'(1);
        valid_d    = 1'b1;
        state_d    = POP_HOLD;
        if (push_re) ovf_set = 1'b1;
      end
      POP_HOLD: begin
        if (push_re) ovf_set = 1'b1;
        if (!stk_pop) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // New error beats a same-cycle clear
    ovf_d = (ovf_q & ~stk_clr) | ovf_set;
    udf_d = (udf_q & ~stk_clr) | udf_set;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q    <= IDLE;
      sp_q       <= '0;
      pop_data_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      pop_data_q <= pop_data_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      push_q     <= stk_push;
      pop_q      <= stk_pop;
    end
  end

  assign pop_data      = pop_data_q;
  assign stk_pop_valid = valid_q;
  assign stk_ovf       = ovf_q;
  assign stk_udf       = udf_q;
  assign sp            = sp_q;
endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: pop tasks queue the expected value and
// the cycle in which valid must rise; a monitor checks each valid rise.
module tb_stack_unit;
  import cpu_pkg::*;

  localparam int DW = 16;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          init_n = 1'b0;
  logic          stk_push = 1'b0, stk_pop = 1'b0, stk_clr = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] pop_data;
  logic          stk_pop_valid, stk_full, stk_empty, stk_ovf, stk_udf;
  logic [SW-1:0] sp;

  stack_unit dut (
    .clk(clk), .init_n(init_n), .stk_push(stk_push), .stk_pop(stk_pop),
    .push_data(push_data), .stk_clr(stk_clr), .pop_data(pop_data),
    .stk_pop_valid(stk_pop_valid), .stk_full(stk_full), .stk_empty(stk_empty),
    .stk_ovf(stk_ovf), .stk_udf(stk_udf), .sp(sp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every rising edge of stk_pop_valid against the queue
  logic vprev = 1'b0;
  always @(negedge clk) begin
    if (!init_n) vprev = 1'b0;
    else begin
      if (stk_pop_valid && !vprev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pop_data", int'(pop_data), int'(e.data));
          check("pop_latency_cycle", cyc, e.due);
        end
      end
      vprev = stk_pop_valid;
    end
  end

  task automatic do_push(input logic [DW-1:0] v);
    @(posedge clk); #1;
    push_data = v; stk_push = 1'b1;
    repeat (3) @(posedge clk);
    #1 stk_push = 1'b0;
    @(posedge clk); #1;
  endtask

  // stk_pop held 3 cycles; valid due 2 cycles after the first high cycle
  task automatic do_pop(input logic [DW-1:0] v, input bit expect_valid);
    exp_t e;
    @(posedge clk); #1;
    stk_pop = 1'b1;
    if (expect_valid) begin
      e.data = v; e.due = cyc + 2;
      exp_q.push_back(e);
    end
    repeat (3) @(posedge clk);
    #1 stk_pop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 init_n = 1'b0; stk_push = 1'b0; stk_pop = 1'b0;
    repeat (2) @(posedge clk);
    #1 init_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    do_reset();
    @(negedge clk);
    check("rst_sp", int'(sp), 0);
    check("rst_empty", int'(stk_empty), 1);
    check("rst_full", int'(stk_full), 0);
    check("rst_valid", int'(stk_pop_valid), 0);
    check("rst_ovf", int'(stk_ovf), 0);
    check("rst_udf", int'(stk_udf), 0);

    // Basic LIFO order
    do_push(16'h1234);
    check("sp_after_push1", int'(sp), 1);
    do_push(16'hBEEF);
    check("sp_after_push2", int'(sp), 2);
    do_pop(16'hBEEF, 1'b1);
    check("sp_after_pop1", int'(sp), 1);
    do_pop(16'h1234, 1'b1);
    check("sp_after_pop2", int'(sp), 0);
    check("empty_after_pops", int'(stk_empty), 1);

    // Fill to full, overflow, pop top
    for (int i = 0; i < 16; i++) do_push(DW'(i));
    check("full_flag", int'(stk_full), 1);
    check("full_sp", int'(sp), 16);
    check("ovf_before", int'(stk_ovf), 0);
    do_push(16'hAAAA);
    check("ovf_sp_held", int'(sp), 16);
    check("ovf_set", int'(stk_ovf), 1);
    do_pop(16'd15, 1'b1);
    check("sp_after_full_pop", int'(sp), 15);
    check("full_cleared", int'(stk_full), 0);

    // Pop on empty: valid must stay low, udf sets
    do_reset();
    @(posedge clk); #1 stk_pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("udf_valid_low", int'(stk_pop_valid), 0);
    end
    @(posedge clk); #1 stk_pop = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("udf_set", int'(stk_udf), 1);
    check("udf_sp", int'(sp), 0);
    @(posedge clk); #1 stk_clr = 1'b1;
    @(posedge clk); #1 stk_clr = 1'b0;
    @(negedge clk);
    check("udf_cleared", int'(stk_udf), 0);

    // Push/pop conflict at sp=3
    do_push(16'h0001); do_push(16'h0002); do_push(16'h0003);
    @(posedge clk); #1 stk_push = 1'b1; stk_pop = 1'b1;
    repeat (3) @(posedge clk);
    #1 stk_push = 1'b0; stk_pop = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("conflict_sp", int'(sp), 3);
    check("conflict_ovf", int'(stk_ovf), 1);
    check("conflict_udf", int'(stk_udf), 1);

    // Async reset while in POP_RD
    @(posedge clk); #1 stk_pop = 1'b1;
    @(posedge clk); #1;
    check("in_pop_rd", int'(dut.state_q), int'(POP_RD));
    init_n = 1'b0; stk_pop = 1'b0;
    #1;
    check("midpop_rst_sp", int'(sp), 0);
    check("midpop_rst_valid", int'(stk_pop_valid), 0);
    check("midpop_rst_state", int'(dut.state_q), int'(IDLE));
    repeat (2) @(posedge clk);
    #1 init_n = 1'b1;
    do_push(16'h0042);
    do_pop(16'h0042, 1'b1);
    check("final_sp", int'(sp), 0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
